// File: rtl/conv_window_gen.sv
// KxK sliding-window generator: K-1 line buffers feed a KxK register window over a raster pixel stream.
// Optional macro WINDOW_STRIDE2_EN restricts window_valid to stride-2 output positions.
module conv_window_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 5,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            pixel_in,
  output logic [K*K*DATA_W-1:0]        window,
  output logic                         window_valid,
  output logic [$clog2(IMG_H)-1:0]     out_row,
  output logic [$clog2(IMG_W)-1:0]     out_col,
  output logic                         frame_done
);

  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned CW  = $clog2(IMG_W);
  localparam int unsigned NLB = K - 1;

  logic [DATA_W-1:0] lb [NLB][IMG_W];
  logic [DATA_W-1:0] tap [K];
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              win_pos;
  logic              hit;
  logic [RW-1:0]     rdiff;
  logic [CW-1:0]     cdiff;
  logic [RW-1:0]     nxt_orow;
  logic [CW-1:0]     nxt_ocol;

  assign accept   = valid_in && !rst;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign win_pos  = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  assign rdiff    = row - RW'(K - 1);
  assign cdiff    = col - CW'(K - 1);

`ifdef WINDOW_STRIDE2_EN
  assign hit      = win_pos && !rdiff[0] && !cdiff[0];
  assign nxt_orow = rdiff >> 1;
  assign nxt_ocol = cdiff >> 1;
`else
  assign hit      = win_pos;
  assign nxt_orow = rdiff;
  assign nxt_ocol = cdiff;
`endif

  // tap[0] is the incoming pixel, tap[k] the pixel k rows above it in the same column
  always_comb begin
    tap[0] = pixel_in;
    for (int k = 1; k < int'(K); k++) begin
      tap[k] = lb[k-1][col];
    end
  end

  // Line buffers are not reset; stale contents are masked by the row/col validity rule
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < int'(NLB); j++) begin
        lb[j][col] <= tap[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window       <= '0;
      window_valid <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
      frame_done   <= 1'b0;
      row          <= '0;
      col          <= '0;
    end else if (valid_in) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          window[(r*K+c)*DATA_W +: DATA_W] <= window[(r*K+c+1)*DATA_W +: DATA_W];
        end
        window[(r*K+K-1)*DATA_W +: DATA_W] <= tap[K-1-r];
      end
      window_valid <= hit;
      frame_done   <= last_row && last_col;
      if (hit) begin
        out_row <= nxt_orow;
        out_col <= nxt_ocol;
      end
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised bench for conv_window_gen: frame-array reference model checked every cycle.
module tb_conv_window_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned K      = 5;
  localparam int unsigned IMG_W  = 28;
  localparam int unsigned IMG_H  = 28;
  localparam int unsigned WW     = K * K * DATA_W;
  localparam int unsigned RW     = $clog2(IMG_H);
  localparam int unsigned CW     = $clog2(IMG_W);
`ifdef WINDOW_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int OH = (IMG_H - K + 1 + STRIDE - 1) / STRIDE;
  localparam int OW = (IMG_W - K + 1 + STRIDE - 1) / STRIDE;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_W-1:0] pixel_in;
  logic [WW-1:0]     window;
  logic              window_valid;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic              frame_done;

  conv_window_gen #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pixel_in(pixel_in),
    .window(window), .window_valid(window_valid), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: current frame image and raster position
  int          img [IMG_H][IMG_W];
  int          m_row, m_col;
  logic [WW-1:0] exp_win;
  logic        exp_valid, exp_done, exp_zero;
  int          exp_orow, exp_ocol;
  int          acc_in_frame, first_valid_acc, pulses, done_pulses;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare sampled outputs
  task automatic cyc(input logic v, input logic [DATA_W-1:0] p, input logic r);
    int rr, cc;
    valid_in = v; pixel_in = p; rst = r;
    @(posedge clk);
    #1;
    exp_zero = 1'b0;
    if (r) begin
      m_row = 0; m_col = 0; exp_valid = 0; exp_done = 0;
      exp_win = '0; exp_orow = 0; exp_ocol = 0; exp_zero = 1'b1;
      acc_in_frame = 0;
    end else if (v) begin
      img[m_row][m_col] = int'(p);
      acc_in_frame++;
      rr = m_row - int'(K) + 1;
      cc = m_col - int'(K) + 1;
      exp_valid = (rr >= 0) && (cc >= 0) && (rr % STRIDE == 0) && (cc % STRIDE == 0);
      exp_done  = (m_row == int'(IMG_H) - 1) && (m_col == int'(IMG_W) - 1);
      if (exp_valid) begin
        exp_orow = rr / STRIDE;
        exp_ocol = cc / STRIDE;
        for (int i = 0; i < int'(K); i++)
          for (int j = 0; j < int'(K); j++)
            exp_win[(i*K+j)*DATA_W +: DATA_W] = DATA_W'(img[rr+i][cc+j]);
      end
      m_col++;
      if (m_col == int'(IMG_W)) begin
        m_col = 0;
        m_row = (m_row == int'(IMG_H) - 1) ? 0 : m_row + 1;
      end
    end else begin
      exp_valid = 0; exp_done = 0;
    end
    check("window_valid", WW'(window_valid), WW'(exp_valid));
    check("frame_done", WW'(frame_done), WW'(exp_done));
    if (exp_valid || exp_zero) begin
      check("window", window, exp_win);
      check("out_row", WW'(out_row), WW'(exp_orow));
      check("out_col", WW'(out_col), WW'(exp_ocol));
    end
    if (window_valid) begin
      pulses++;
      if (first_valid_acc < 0) first_valid_acc = acc_in_frame;
    end
    if (frame_done) done_pulses++;
    if (v && !r && m_row == 0 && m_col == 0) acc_in_frame = 0;
  endtask

  task automatic run_frame(input int off, input int gap_pct, input bit rnd);
    logic [DATA_W-1:0] p;
    for (int r = 0; r < int'(IMG_H); r++) begin
      for (int c = 0; c < int'(IMG_W); c++) begin
        while (int'($urandom_range(99)) < gap_pct) cyc(1'b0, DATA_W'($urandom), 1'b0);
        p = rnd ? DATA_W'($urandom) : DATA_W'((r * int'(IMG_W) + c + off) % 256);
        cyc(1'b1, p, 1'b0);
      end
    end
  endtask

  task automatic start_stats();
    pulses = 0; done_pulses = 0; first_valid_acc = -1;
  endtask

  initial begin
    valid_in = 0; pixel_in = '0; rst = 1;
    m_row = 0; m_col = 0; exp_win = '0; exp_valid = 0; exp_done = 0;
    exp_orow = 0; exp_ocol = 0; acc_in_frame = 0;
    start_stats();
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Continuous ramp frame
    start_stats();
    run_frame(0, 0, 1'b0);
    check("pulse_count_s1", WW'(pulses), WW'(OH * OW));
    check("first_valid_accept", WW'(first_valid_acc), WW'((K - 1) * IMG_W + K));
    check("frame_done_count_s1", WW'(done_pulses), WW'(1));

    // Same ramp with idle gaps
    start_stats();
    run_frame(0, 40, 1'b0);
    check("pulse_count_s2", WW'(pulses), WW'(OH * OW));

    // Two back-to-back frames, second offset by 100
    start_stats();
    run_frame(0, 0, 1'b0);
    run_frame(100, 0, 1'b0);
    check("frame_done_count_s4", WW'(done_pulses), WW'(2));
    check("pulse_count_s4", WW'(pulses), WW'(2 * OH * OW));

    // Reset after 300 accepts, with valid_in high during reset
    for (int n = 0; n < 300; n++) cyc(1'b1, DATA_W'($urandom), 1'b0);
    cyc(1'b1, DATA_W'($urandom), 1'b1);
    start_stats();
    run_frame(0, 0, 1'b0);
    check("pulse_count_s5", WW'(pulses), WW'(OH * OW));
    check("first_valid_accept_s5", WW'(first_valid_acc), WW'((K - 1) * IMG_W + K));

    // Random pixels with random gaps, two frames
    start_stats();
    run_frame(0, 30, 1'b1);
    run_frame(0, 15, 1'b1);
    check("pulse_count_rand", WW'(pulses), WW'(2 * OH * OW));
    check("frame_done_count_rand", WW'(done_pulses), WW'(2));

    for (int n = 0; n < 3; n++) cyc(1'b0, '0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Parametrised KxK sliding-window generator for the LeNet-5 conv/pool datapath.
- Accepts a raster-order pixel stream, one pixel per valid_in cycle.
- Holds K-1 internal line buffers of IMG_W entries, plus a KxK shift-register window.
- Emits a flattened window with window_valid only at positions where the window lies fully inside the image, together with output coordinates and an end-of-frame pulse.

Parameters:
- DATA_W, 8: pixel width in bits.
- K, 5: window size (KxK); K >= 2.
- IMG_W, 28: image width in pixels; IMG_W >= K.
- IMG_H, 28: image height in pixels; IMG_H >= K.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  pixel_in valid; one pixel accepted per cycle when high.
- pixel_in  input  DATA_W  raster-order pixel, row-major, top-left first.
- window  output  K*K*DATA_W  flattened window. Element (r,c) occupies bits [(r*K+c+1)*DATA_W-1 : (r*K+c)*DATA_W].
  - r=0 is the oldest row; c=0 is the oldest column.
  - (K-1,K-1) is the newest pixel.
- window_valid  output  1  window holds a complete in-image KxK neighbourhood.
- out_row  output  $clog2(IMG_H)  output-map row of the current window.
- out_col  output  $clog2(IMG_W)  output-map column of the current window.
- frame_done  output  1  one-cycle pulse marking the last window of the frame.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high (rst); no asynchronous reset path.
- Reset values:
  - window = 0, window_valid = 0, out_row = 0, out_col = 0, frame_done = 0.
  - Internal col counter = 0, row counter = 0.
  - Line buffer RAM contents are not cleared.
- Accept: on a clk edge with valid_in=1 and rst=0, the pixel at the current (row,col) is consumed.
  - Line buffer k (k=1..K-1) supplies the pixel at (row-k, col) and then stores the pixel at (row-k+1, col).
  - Window rows shift one column left.
  - Column K-1 loads: row K-1 <= pixel_in, and row r <= line buffer tap (K-1-r).
- Stall: valid_in=0 freezes every register, counter and line buffer. Outputs hold their values, except window_valid and frame_done, which drop to 0.
- Counters:
  - col increments per accept; at IMG_W-1 it wraps to 0 and row increments.
  - At row IMG_H-1, col IMG_W-1 both wrap to 0, so the next frame starts with no idle cycle required.
- Latency: window_valid goes high in the cycle after the accept of pixel (row,col) iff row >= K-1 and col >= K-1.
  - In that cycle, out_row = row-(K-1) and out_col = col-(K-1).
  - window_valid is 0 after accepts where col < K-1. This suppresses row-wrap garbage, with no extra flush.
- Output count: (IMG_H-K+1)*(IMG_W-K+1) window_valid pulses per frame (576 for the defaults).
- frame_done: high in the same cycle as window_valid for the pixel (IMG_H-1, IMG_W-1).
- Stale line-buffer data from a previous frame or a pre-reset run never appears under window_valid=1.
- Reset mid-frame: the partial frame is abandoned; the next accepted pixel is (0,0) of a new frame.
- Simultaneous rst and valid_in: rst wins; the pixel is dropped.
- No backpressure: downstream must accept every window_valid cycle.

Optional Feature:
- Macro WINDOW_STRIDE2_EN.
- Defined:
  - window_valid is additionally gated to positions where (row-(K-1)) and (col-(K-1)) are both even.
  - out_row and out_col report the strided indices, (row-(K-1))/2 and (col-(K-1))/2.
  - Pulse count per frame = ceil((IMG_H-K+1)/2)*ceil((IMG_W-K+1)/2).
  - frame_done fires at the last strided window, or with the last accept if that position is not strided-valid.
- Undefined: stride 1 as described above. The gating logic is absent from the build.

Test Plan:
1. Defaults; stream 784 pixels with pixel=(r*28+c) mod 256 and valid_in held high:
   - First window_valid occurs one cycle after the 117th accept.
   - That window: element(0,0)=0, (0,4)=4, (4,0)=112, (4,4)=116; out_row=0, out_col=0.
   - Exactly 576 pulses are produced.
2. Same stream with pseudo-random valid_in gaps (about 40% idle) -> the window, out_row, out_col sequence is identical to scenario 1. window_valid and frame_done are never high in idle-following cycles.
3. Row wrap: accepts of pixels (5,0)..(5,3) -> window_valid=0. Accept of (5,4) -> window_valid=1, out_row=1, out_col=0, element(0,0)=28.
4. Two back-to-back frames, the second with values +100 -> the second frame's first window has element(0,0)=100. There is no contamination from frame 1, and frame_done pulses exactly twice, each with out_row=23, out_col=23.
5. Assert rst for 1 cycle after 300 accepts:
   - Next cycle: all outputs are 0.
   - A following full frame reproduces scenario 1 exactly.
   - rst asserted with valid_in=1 drops that pixel.
6. With WINDOW_STRIDE2_EN defined, run scenario 1 -> 144 pulses, out_row and out_col in 0..11. The window at out_row=1, out_col=1 has element(0,0)=58.
